pc_fetch_ctrl: RTL and testbench

- Fetch sequencer that drives the program counter's enable, select and branch-target inputs.
- Boots the PC to a reset vector, because the PC itself has no reset.
- Issues one instruction-memory request per PC value and waits for a ready handshake.
- Buffers one pending branch redirect, flushes the wrong-path fetch, and handles stall, halt and memory timeout.

---
 rtl/pc_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer for an external, reset-less PC: boots it to RESET_VEC, issues one
// imem request per PC value, buffers one branch redirect and flushes the wrong-path fetch.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// BOOT   | load RESET_VEC into the PC
// REQ    | issue the imem request, clear the wait counter
// WAIT   | hold the request until imem_ready or timeout
// ADV    | update the PC (increment, pending redirect or bypassed branch)
// HALTED | stopped, start resumes at the current PC
// ERR    | memory timeout, sticky until rst
module pc_fetch_ctrl #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                MAX_WAIT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ack,
  output logic              imem_req,
  input  logic              imem_ready,
  output logic              instr_valid,
  output logic              flush,
  output logic              pc_en,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              fetch_err,
  output logic [2:0]        state_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BOOT   = 3'd1,
    REQ    = 3'd2,
    WAIT   = 3'd3,
    ADV    = 3'd4,
    HALTED = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic              pend_valid, pend_valid_nxt;
  logic [ADDR_W-1:0] pend_target, pend_target_nxt;
  logic [ADDR_W-1:0] tgt_q;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;

  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_target <= RESET_VEC;
      wait_cnt    <= '0;
      tgt_q       <= RESET_VEC;
    end else begin
      state       <= state_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      wait_cnt    <= wait_cnt_nxt;
      tgt_q       <= pc_target;
    end
  end

  always_comb begin
    state_nxt       = state;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    wait_cnt_nxt    = wait_cnt;
    imem_req        = 1'b0;
    instr_valid     = 1'b0;
    flush           = 1'b0;
    pc_en           = 1'b0;
    pc_sel          = 1'b0;
    pc_target       = tgt_q;
    fetch_err       = 1'b0;

    br_ack = br_valid && !pend_valid &&
             ((state == REQ) || (state == WAIT) || (state == ADV));

    // An unstalled ADV consumes the branch directly; every other ack is buffered.
    if (br_ack && !((state == ADV) && !stall)) begin
      pend_valid_nxt  = 1'b1;
      pend_target_nxt = br_target;
    end

    case (state)
      IDLE: begin
        if (start) state_nxt = BOOT;
      end
      BOOT: begin
        pc_en     = 1'b1;
        pc_sel    = 1'b1;
        pc_target = RESET_VEC;
        state_nxt = REQ;
      end
      REQ: begin
        imem_req     = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = WAIT;
      end
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (pend_valid || br_ack) flush = 1'b1;
          else                      instr_valid = 1'b1;
          state_nxt = ADV;
        end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ADV: begin
        if (!stall) begin
          pc_en = 1'b1;
          if (pend_valid) begin
            pc_sel         = 1'b1;
            pc_target      = pend_target;
            pend_valid_nxt = 1'b0;
          end else if (br_valid) begin
            pc_sel    = 1'b1;
            pc_target = br_target;
          end
          state_nxt = halt ? HALTED : REQ;
        end
      end
      HALTED: begin
        if (start) state_nxt = REQ;
      end
      ERR: begin
        fetch_err = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: models the external PC and scoreboards every fetch
// (address and flush flag) against expectations queued by the stimulus.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, halt, stall, br_valid, imem_ready;
  logic [11:0] br_target;
  logic        br_ack, imem_req, instr_valid, flush, pc_en, pc_sel, fetch_err;
  logic [11:0] pc_target;
  logic [2:0]  state_o;

  pc_fetch_ctrl #(.ADDR_W(12), .RESET_VEC(12'h000), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .stall(stall),
    .br_valid(br_valid), .br_target(br_target), .br_ack(br_ack),
    .imem_req(imem_req), .imem_ready(imem_ready), .instr_valid(instr_valid),
    .flush(flush), .pc_en(pc_en), .pc_sel(pc_sel), .pc_target(pc_target),
    .fetch_err(fetch_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // External PC: no reset, loads or increments when enabled.
  logic [11:0] pc_m;
  always @(posedge clk) if (pc_en) pc_m <= pc_sel ? pc_target : pc_m + 12'd1;

  typedef struct packed {
    logic [11:0] addr;
    logic        fl;
  } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs, score any fetch completion, advance to next negedge.
  task automatic cyc();
    exp_t e;
    #1;
    if (instr_valid || flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fetch", 32'(pc_m), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("fetch_addr", 32'(pc_m), 32'(e.addr));
        chk("fetch_flush", 32'(flush), 32'(e.fl));
        chk("fetch_valid", 32'(instr_valid), 32'(!e.fl));
      end
    end
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [11:0] a, input logic f);
    exp_t e;
    e.addr = a;
    e.fl   = f;
    return e;
  endfunction

  logic [11:0] pc_hold;
  int          waits;

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
    br_valid = 1'b0; br_target = 12'h000; imem_ready = 1'b0;
    #3;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_fetch_err", 32'(fetch_err), 0);
    chk("rst_br_ack", 32'(br_ack), 0);
    chk("rst_pc_target", 32'(pc_target), 0);
    @(negedge clk);
    rst = 1'b0;

    // Boot and sequential fetch at 0, 1, 2
    start = 1'b1;
    cyc();
    start = 1'b0;
    imem_ready = 1'b1;
    #1;
    chk("boot_state", 32'(state_o), 1);
    chk("boot_pc_en", 32'(pc_en), 1);
    chk("boot_pc_sel", 32'(pc_sel), 1);
    chk("boot_pc_target", 32'(pc_target), 0);
    exp_q.push_back(mk(12'h000, 1'b0));
    exp_q.push_back(mk(12'h001, 1'b0));
    exp_q.push_back(mk(12'h002, 1'b0));
    for (int i = 0; i < 9; i++) cyc();
    chk("seq_q_empty", 32'(exp_q.size()), 0);
    chk("seq_state_adv", 32'(state_o), 4);

    // Branch bypass in ADV
    br_valid = 1'b1; br_target = 12'h0A5;
    #1;
    chk("byp_br_ack", 32'(br_ack), 1);
    chk("byp_pc_sel", 32'(pc_sel), 1);
    chk("byp_pc_target", 32'(pc_target), 32'h0A5);
    exp_q.push_back(mk(12'h0A5, 1'b0));
    cyc();
    br_valid = 1'b0;
    cyc(); cyc();
    #1;
    chk("inc_pc_sel", 32'(pc_sel), 0);
    chk("hold_pc_target", 32'(pc_target), 32'h0A5);
    cyc();

    // Branch captured in WAIT, wrong-path fetch at 0xA6 flushed
    imem_ready = 1'b0;
    cyc();
    br_valid = 1'b1; br_target = 12'h100;
    #1;
    chk("wait_state", 32'(state_o), 3);
    chk("wait_br_ack", 32'(br_ack), 1);
    chk("wait_imem_req", 32'(imem_req), 1);
    cyc();
    br_valid = 1'b0;
    cyc();
    imem_ready = 1'b1;
    exp_q.push_back(mk(12'h0A6, 1'b1));
    #1;
    chk("flush_pulse", 32'(flush), 1);
    chk("flush_no_valid", 32'(instr_valid), 0);
    cyc();

    // Stall in ADV with a pending redirect; new branch refused while pending
    stall = 1'b1; br_valid = 1'b1; br_target = 12'h03C;
    pc_hold = pc_m;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_pc_en", 32'(pc_en), 0);
      chk("stall_br_ack", 32'(br_ack), 0);
      chk("stall_state", 32'(state_o), 4);
      cyc();
    end
    chk("stall_pc_hold", 32'(pc_m), 32'(pc_hold));
    stall = 1'b0;
    #1;
    chk("pend_pc_sel", 32'(pc_sel), 1);
    chk("pend_pc_target", 32'(pc_target), 32'h100);
    chk("pend_br_ack", 32'(br_ack), 0);
    exp_q.push_back(mk(12'h100, 1'b1));
    exp_q.push_back(mk(12'h03C, 1'b0));
    cyc();
    #1;
    chk("req_br_ack", 32'(br_ack), 1);
    cyc();
    br_valid = 1'b0;
    cyc();
    #1;
    chk("adv_pend_target", 32'(pc_target), 32'h03C);
    cyc(); cyc(); cyc();

    // Halt together with a branch, then resume at the target
    halt = 1'b1; br_valid = 1'b1; br_target = 12'h2F0;
    #1;
    chk("halt_br_ack", 32'(br_ack), 1);
    cyc();
    halt = 1'b0; br_valid = 1'b0;
    cyc(); cyc();
    chk("halted_state", 32'(state_o), 5);
    chk("halted_pc_en", 32'(pc_en), 0);
    chk("halted_imem_req", 32'(imem_req), 0);
    start = 1'b1;
    exp_q.push_back(mk(12'h2F0, 1'b0));
    cyc();
    start = 1'b0;
    cyc(); cyc();
    chk("resume_q_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of WAIT
    cyc();
    imem_ready = 1'b0;
    cyc();
    #1;
    chk("pre_rst_imem_req", 32'(imem_req), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_o), 0);
    chk("async_rst_imem_req", 32'(imem_req), 0);
    chk("async_rst_pc_target", 32'(pc_target), 0);
    @(negedge clk);
    rst = 1'b0;

    // Memory timeout
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    waits = 0;
    for (int i = 0; i < 40 && state_o != 3'd6; i++) begin
      if (state_o == 3'd3) waits++;
      cyc();
    end
    chk("err_state", 32'(state_o), 6);
    chk("err_wait_cycles", 32'(waits), 16);
    start = 1'b1;
    cyc(); cyc();
    #1;
    chk("err_sticky_flag", 32'(fetch_err), 1);
    chk("err_sticky_state", 32'(state_o), 6);
    chk("err_imem_req", 32'(imem_req), 0);
    rst = 1'b1;
    #1;
    chk("err_cleared", 32'(fetch_err), 0);
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
